sonic_xgmii_frame_gen: RTL and testbench
========================================

Name: sonic_xgmii_frame_gen

Overview:
Test-traffic source that sits directly upstream of the single-port PHY. It drives the 72-bit interleaved XGMII TX bus (xgmii_tx_data) with back-to-back Ethernet-style frames separated by idle columns, for link bring-up and clocksync characterisation without a MAC. Frames carry a 32-bit sequence number so the RX side can detect loss and reordering.

Parameters:
MIN_LEN, 64, minimum payload bytes; smaller requests are clamped up to this value.
MIN_IPG, 12, minimum inter-frame idle bytes; smaller requests are clamped up to this value.

Ports:
clk_in  input  1  PHY core clock; the only clock.
rst_in  input  1  synchronous, active-high reset.
link_ready  input  1  new frames start only while this is high.
ctrl_enable  input  1  level; generate frames while high.
ctrl_clear  input  1  one-cycle pulse; clears frame_count and done.
ctrl_frame_len  input  14  payload bytes after SFD, including the sequence field.
ctrl_ipg  input  8  requested idle bytes between frames.
ctrl_num_frames  input  32  frames to send; 0 means unlimited.
xgmii_tx_data  output  72  interleaved XGMII column. Lane i occupies bits [9i+8:9i]; bit 9i+8 is control, bits [9i+7:9i] are data. Lane 0 is the first byte on the wire.
busy  output  1  high from the START column through the last IPG column.
done  output  1  ctrl_num_frames frames have been sent.
frame_count  output  32  frames completed since reset or clear.

Behaviour:
- Reset and output timing
  - All outputs are registered.
  - Reset values: xgmii_tx_data is the idle column (every lane = 9'h107, ctrl=1, 0x07); busy=0; done=0; frame_count=0; state=IDLE.
  - Reset asserted mid-frame: the next column is idle. No terminate is emitted and frame_count does not increment.
- Column encoding
  - Idle: lane ctrl=1, data 0x07.
  - START column: lane0 = ctrl 0xFB; lanes1-6 = data 0x55; lane7 = data 0xD5.
  - Payload bytes are data (ctrl=0). Byte k: k=0..3 carry seq[8k+7:8k] (little-endian); k≥4 carries k[7:0].
  - seq equals frame_count at frame start.
- Per-frame latching: at frame start the block latches L = max(ctrl_frame_len, MIN_LEN) and G = max(ctrl_ipg, MIN_IPG). Changes mid-frame have no effect.
- FSM states and transitions
  - IDLE → START when ctrl_enable && link_ready && !done. The START column appears on the output the cycle after this condition is sampled.
  - START → DATA.
  - DATA emits 8 payload bytes per column for floor(L/8) full columns. Let r = L mod 8.
    - r≠0: the final column carries bytes in lanes 0..r-1, lane r = ctrl 0xFD, lanes r+1..7 idle. Next state is IPG.
    - r=0: after the last full column the block goes to TERM.
  - TERM emits lane0 = ctrl 0xFD, lanes1-7 idle, then goes to IPG.
  - IPG emits ceil(G/8) full idle columns, then returns to IDLE. Trailing idles in the terminate column do not count toward G.
- frame_count
  - Increments on the cycle the column containing 0xFD is emitted.
  - Wraps modulo 2^32.
- done
  - Set when frame_count reaches ctrl_num_frames (nonzero) on terminate. The generator then stays in IDLE.
  - Cleared only by ctrl_clear or rst_in.
- ctrl_clear: clears frame_count and done. If it coincides with a terminate, the clear wins (count=0).
- ctrl_enable or link_ready dropping mid-frame: the current frame and its IPG complete; no new frame starts.
- busy is low only in IDLE.
- Throughput: minimum spacing between START columns is 1 + ceil(L/8) + (r==0) + ceil(G/8) cycles.

Decomposition:
- Package sonic_xgmii_pkg holds:
  - byte constants XGMII_IDLE=8'h07, XGMII_START=8'hFB, XGMII_TERM=8'hFD, XGMII_PREAMBLE=8'h55, XGMII_SFD=8'hD5;
  - the 9'h107 idle-lane constant;
  - the FSM state enum {IDLE, START, DATA, TERM, IPG};
  - the lane-pack function index helpers.
- Sub-module sonic_xgmii_lane_pack: combinational. Packs 64-bit data plus 8-bit ctrl into the 72-bit interleaved column; shared later with the RX checker.

Test Plan:
- Reset release, ctrl_enable=0 → xgmii_tx_data constant 8×9'h107; busy=0; frame_count=0.
- L=64, G=12, num_frames=1, enable → one START column (lane0 0x1FB, lane7 0x0D5); 8 data columns with bytes 0-3 = 00 00 00 00 and byte 4 = 0x04; then a TERM column (lane0 0x1FD); then 2 idle columns. done=1, frame_count=1, and no second START.
- L=67 → final data column has lanes0-2 = 0x40,0x41,0x42; lane3 = 0x1FD; lanes4-7 = 0x107; no separate TERM column.
- num_frames=0, L=64, G=20 for 5 frames → START columns spaced exactly 13 cycles apart; sequence fields 0,1,2,3,4.
- ctrl_frame_len=10, ctrl_ipg=3 → behaves as L=64, G=12. Change len to 100 mid-frame → the current frame is still 64 bytes.
- rst_in asserted during a DATA column → next column is idle, frame_count unchanged. Separately, ctrl_clear coincident with terminate → frame_count=0, done=0.

Source files
------------

// File: rtl/sonic_xgmii_pkg.sv
// Shared XGMII constants, generator FSM states and lane-index helpers for the
// sonic test-traffic source and its RX checker.
package sonic_xgmii_pkg;

    localparam logic [7:0] XGMII_IDLE     = 8'h07;
    localparam logic [7:0] XGMII_START    = 8'hFB;
    localparam logic [7:0] XGMII_TERM     = 8'hFD;
    localparam logic [7:0] XGMII_PREAMBLE = 8'h55;
    localparam logic [7:0] XGMII_SFD      = 8'hD5;

    localparam logic [8:0] XGMII_IDLE_LANE = 9'h107;

    localparam int LANES  = 8;
    localparam int LANE_W = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        TERM,
        IPG
    } state_t;

    function automatic int lane_data_lsb(input int lane);
        return lane * LANE_W;
    endfunction

    function automatic int lane_ctrl_bit(input int lane);
        return lane * LANE_W + 8;
    endfunction

endpackage

// File: rtl/sonic_xgmii_lane_pack.sv
// Packs a 64-bit data word and 8 per-lane control flags into one 72-bit
// interleaved XGMII column (lane i = {ctrl[i], data[8i+7:8i]}).
module sonic_xgmii_lane_pack
    import sonic_xgmii_pkg::*;
(
    input  logic [63:0] data,
    input  logic [7:0]  ctrl,
    output logic [71:0] column
);

    always_comb begin
        column = '0;
        for (int i = 0; i < LANES; i++) begin
            column[lane_data_lsb(i) +: 8] = data[8*i +: 8];
            column[lane_ctrl_bit(i)]      = ctrl[i];
        end
    end

endmodule

// File: rtl/sonic_xgmii_frame_gen.sv
// XGMII test-frame generator: back-to-back frames carrying a 32-bit sequence
// number, separated by idle columns, with frame counting and a stop count.
module sonic_xgmii_frame_gen
    import sonic_xgmii_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MIN_IPG = 12
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        link_ready,
    input  logic        ctrl_enable,
    input  logic        ctrl_clear,
    input  logic [13:0] ctrl_frame_len,
    input  logic [7:0]  ctrl_ipg,
    input  logic [31:0] ctrl_num_frames,
    output logic [71:0] xgmii_tx_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] frame_count
);

    state_t      state, state_next;
    logic [10:0] data_col, data_col_next;
    logic [5:0]  ipg_cnt, ipg_cnt_next;

    logic [10:0] last_col_q;
    logic [2:0]  rem_q;
    logic [5:0]  ipg_cols_q;
    logic [31:0] seq_q;

    logic        start_ok;
    logic        go_start;
    logic        emit_data;
    logic        emit_term;
    logic        partial;
    logic        terminate;

    logic [13:0] len_eff;
    logic [7:0]  ipg_eff;
    logic [14:0] len_round;
    logic [11:0] len_cols;
    logic [8:0]  ipg_round;

    logic [63:0] col_data;
    logic [7:0]  col_ctrl;
    logic [71:0] col_next;

    logic [31:0] count_next;
    logic        done_next;

    assign start_ok = ctrl_enable && link_ready && !done;

    // Clamped per-frame geometry, sampled only when a frame starts.
    assign len_eff   = (ctrl_frame_len < 14'(MIN_LEN)) ? 14'(MIN_LEN) : ctrl_frame_len;
    assign ipg_eff   = (ctrl_ipg < 8'(MIN_IPG)) ? 8'(MIN_IPG) : ctrl_ipg;
    assign len_round = {1'b0, len_eff} + 15'd7;
    assign len_cols  = len_round[14:3];
    assign ipg_round = {1'b0, ipg_eff} + 9'd7;

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_next    = state;
        data_col_next = data_col;
        ipg_cnt_next  = ipg_cnt;
        go_start      = 1'b0;
        emit_data     = 1'b0;
        emit_term     = 1'b0;
        unique case (state)
            IDLE: go_start = start_ok;
            START: begin
                state_next    = DATA;
                data_col_next = '0;
                emit_data     = 1'b1;
            end
            DATA: begin
                if (data_col == last_col_q) begin
                    if (rem_q == 3'd0) begin
                        state_next = TERM;
                        emit_term  = 1'b1;
                    end else begin
                        state_next   = IPG;
                        ipg_cnt_next = ipg_cols_q;
                    end
                end else begin
                    data_col_next = data_col + 11'd1;
                    emit_data     = 1'b1;
                end
            end
            TERM: begin
                state_next   = IPG;
                ipg_cnt_next = ipg_cols_q;
            end
            IPG: begin
                // The last idle column hands straight over to the next START so
                // back-to-back frames lose no extra cycle in IDLE.
                if (ipg_cnt == 6'd1) begin
                    state_next = IDLE;
                    go_start   = start_ok;
                end else begin
                    ipg_cnt_next = ipg_cnt - 6'd1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (go_start) begin
            state_next = START;
        end
    end

    assign partial   = emit_data && (data_col_next == last_col_q) && (rem_q != 3'd0);
    assign terminate = emit_term || partial;

    always_comb begin
        logic [13:0] byte_idx;
        logic [7:0]  lane_byte;
        byte_idx  = '0;
        lane_byte = '0;
        col_data  = {8{XGMII_IDLE}};
        col_ctrl  = 8'hFF;
        if (go_start) begin
            col_data = {XGMII_SFD, {6{XGMII_PREAMBLE}}, XGMII_START};
            col_ctrl = 8'h01;
        end else if (emit_term) begin
            col_data[7:0] = XGMII_TERM;
        end else if (emit_data) begin
            for (int i = 0; i < LANES; i++) begin
                byte_idx = {data_col_next, 3'b000} + 14'(i);
                // Bytes 0..3 carry the little-endian sequence number.
                lane_byte = (byte_idx < 14'd4) ? seq_q[{byte_idx[1:0], 3'b000} +: 8]
                                               : byte_idx[7:0];
                if (partial && (3'(i) == rem_q)) begin
                    col_data[8*i +: 8] = XGMII_TERM;
                    col_ctrl[i]        = 1'b1;
                end else if (partial && (3'(i) > rem_q)) begin
                    col_data[8*i +: 8] = XGMII_IDLE;
                    col_ctrl[i]        = 1'b1;
                end else begin
                    col_data[8*i +: 8] = lane_byte;
                    col_ctrl[i]        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        count_next = frame_count;
        done_next  = done;
        if (terminate) begin
            count_next = frame_count + 32'd1;
            if ((ctrl_num_frames != 32'd0) && (count_next == ctrl_num_frames)) begin
                done_next = 1'b1;
            end
        end
        if (ctrl_clear) begin
            count_next = '0;
            done_next  = 1'b0;
        end
    end

    sonic_xgmii_lane_pack u_lane_pack (
        .data   (col_data),
        .ctrl   (col_ctrl),
        .column (col_next)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            data_col      <= '0;
            ipg_cnt       <= '0;
            xgmii_tx_data <= {8{XGMII_IDLE_LANE}};
            busy          <= 1'b0;
            done          <= 1'b0;
            frame_count   <= '0;
        end else begin
            state         <= state_next;
            data_col      <= data_col_next;
            ipg_cnt       <= ipg_cnt_next;
            xgmii_tx_data <= col_next;
            busy          <= (state_next != IDLE);
            done          <= done_next;
            frame_count   <= count_next;
        end
    end

    // NOTE: frame-geometry registers carry no reset; they are loaded on every
    // frame start before any state that reads them is entered.
    always_ff @(posedge clk_in) begin
        if (go_start) begin
            last_col_q <= 11'(len_cols - 12'd1);
            rem_q      <= len_eff[2:0];
            ipg_cols_q <= ipg_round[8:3];
            seq_q      <= ctrl_clear ? 32'd0 : frame_count;
        end
    end

endmodule

// File: tb/tb_sonic_xgmii_frame_gen.sv
// Self-checking bench for sonic_xgmii_frame_gen: each frame is predicted as a
// byte stream on the wire, chunked into 8-lane columns and compared column by column.
module tb_sonic_xgmii_frame_gen;

    localparam logic [71:0] IDLE_COL  = {8{9'h107}};
    localparam logic [71:0] START_COL = {9'h0D5, {6{9'h055}}, 9'h1FB};
    localparam logic [71:0] TERM_COL  = {{7{9'h107}}, 9'h1FD};

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        link_ready = 1'b1;
    logic        ctrl_enable = 1'b0;
    logic        ctrl_clear = 1'b0;
    logic [13:0] ctrl_frame_len = 14'd64;
    logic [7:0]  ctrl_ipg = 8'd12;
    logic [31:0] ctrl_num_frames = 32'd0;
    logic [71:0] xgmii_tx_data;
    logic        busy;
    logic        done;
    logic [31:0] frame_count;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_start = 0;
    logic [71:0] exp_q[$];

    always #5 clk_in = ~clk_in;

    sonic_xgmii_frame_gen dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .link_ready      (link_ready),
        .ctrl_enable     (ctrl_enable),
        .ctrl_clear      (ctrl_clear),
        .ctrl_frame_len  (ctrl_frame_len),
        .ctrl_ipg        (ctrl_ipg),
        .ctrl_num_frames (ctrl_num_frames),
        .xgmii_tx_data   (xgmii_tx_data),
        .busy            (busy),
        .done            (done),
        .frame_count     (frame_count)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk_in);
        cyc++;
    endtask

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Wire-level model: START + preamble/SFD, payload, terminate, pad to a
    // column boundary, then ceil(G/8) whole idle columns.
    function automatic void build_frame(input int len, input int ipg, input logic [31:0] seq);
        logic [8:0]  w[$];
        logic [71:0] col;
        int l_eff;
        int g_eff;
        l_eff = (len < 64) ? 64 : len;
        g_eff = (ipg < 12) ? 12 : ipg;
        exp_q.delete();
        w.push_back(9'h1FB);
        repeat (6) w.push_back(9'h055);
        w.push_back(9'h0D5);
        for (int k = 0; k < l_eff; k++) begin
            if (k < 4) w.push_back({1'b0, seq[8*k +: 8]});
            else       w.push_back({1'b0, 8'(k)});
        end
        w.push_back(9'h1FD);
        while ((w.size() % 8) != 0) w.push_back(9'h107);
        for (int j = 0; j < ((g_eff + 7) / 8) * 8; j++) w.push_back(9'h107);
        for (int c = 0; c < w.size() / 8; c++) begin
            col = '0;
            for (int i = 0; i < 8; i++) col[9*i +: 9] = w[8*c + i];
            exp_q.push_back(col);
        end
    endfunction

    task automatic wait_start(input string tag, output bit found);
        found = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (xgmii_tx_data === START_COL) begin
                found = 1'b1;
                break;
            end
        end
        last_start = cyc;
        check({tag, " start_seen"}, 72'(found), 72'd1);
    endtask

    task automatic expect_frame(input string tag, input int len, input int ipg,
                                input logic [31:0] seq, input bit drop_en,
                                input logic [13:0] mid_len, input logic [7:0] mid_ipg);
        bit found;
        build_frame(len, ipg, seq);
        wait_start(tag, found);
        if (found) begin
            if (drop_en) ctrl_enable = 1'b0;
            ctrl_frame_len = mid_len;
            ctrl_ipg       = mid_ipg;
            check({tag, " busy"}, 72'(busy), 72'd1);
            for (int j = 1; j < exp_q.size(); j++) begin
                step();
                check($sformatf("%s col%0d", tag, j), xgmii_tx_data, exp_q[j]);
            end
            check({tag, " frame_count"}, 72'(frame_count), 72'(seq + 32'd1));
        end
    endtask

    task automatic pulse_clear();
        ctrl_clear = 1'b1;
        step();
        ctrl_clear = 1'b0;
    endtask

    initial begin
        logic [31:0] seq;
        bit found;
        bit bad;
        int len;
        int ipg;

        // Reset and quiet idle
        repeat (3) step();
        rst_in = 1'b0;
        repeat (3) step();
        check("reset idle", xgmii_tx_data, IDLE_COL);
        check("reset busy", 72'(busy), 72'd0);
        check("reset done", 72'(done), 72'd0);
        check("reset count", 72'(frame_count), 72'd0);

        // Enable without link: nothing starts
        link_ready  = 1'b0;
        ctrl_enable = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            step();
            if (xgmii_tx_data !== IDLE_COL || busy !== 1'b0) bad = 1'b1;
        end
        check("no link no start", 72'(bad), 72'd0);

        // Single 64-byte frame with stop count 1
        ctrl_num_frames = 32'd1;
        link_ready      = 1'b1;
        expect_frame("single", 64, 12, 32'd0, 1'b0, 14'd64, 8'd12);
        check("single done", 72'(done), 72'd1);
        bad = 1'b0;
        repeat (20) begin
            step();
            if (xgmii_tx_data !== IDLE_COL) bad = 1'b1;
        end
        check("single no restart", 72'(bad), 72'd0);
        check("single busy low", 72'(busy), 72'd0);
        ctrl_enable = 1'b0;
        pulse_clear();
        check("clear count", 72'(frame_count), 72'd0);
        check("clear done", 72'(done), 72'd0);

        // L=67: partial last column carries the terminate
        ctrl_num_frames = 32'd0;
        ctrl_frame_len  = 14'd67;
        ctrl_enable     = 1'b1;
        expect_frame("len67", 67, 12, 32'd0, 1'b1, 14'd67, 8'd12);

        // Unlimited back-to-back: 13-cycle START spacing, seq 0..4
        step();
        pulse_clear();
        ctrl_frame_len = 14'd64;
        ctrl_ipg       = 8'd20;
        ctrl_enable    = 1'b1;
        seq = 32'd0;
        for (int n = 0; n < 5; n++) begin
            int prev;
            prev = last_start;
            expect_frame($sformatf("b2b%0d", n), 64, 20, seq, (n == 4), 14'd64, 8'd20);
            if (n > 0) check($sformatf("b2b%0d spacing", n), 72'(last_start - prev), 72'd13);
            seq++;
        end

        // Clamping, and mid-frame length/IPG changes have no effect
        ctrl_frame_len = 14'd10;
        ctrl_ipg       = 8'd3;
        ctrl_enable    = 1'b1;
        expect_frame("clamp", 10, 3, seq, 1'b1, 14'd100, 8'd40);
        seq++;

        // Randomised frame geometry and mid-frame disturbances
        for (int n = 0; n < 6; n++) begin
            len = int'($urandom_range(0, 150));
            ipg = int'($urandom_range(0, 40));
            ctrl_frame_len = 14'(len);
            ctrl_ipg       = 8'(ipg);
            ctrl_enable    = 1'b1;
            expect_frame($sformatf("rnd%0d", n), len, ipg, seq, 1'b1,
                         14'($urandom_range(0, 300)), 8'($urandom_range(0, 60)));
            seq++;
        end

        // Reset during DATA: next column idle, no terminate, count stays 0
        step();
        pulse_clear();
        ctrl_frame_len = 14'd64;
        ctrl_ipg       = 8'd12;
        ctrl_enable    = 1'b1;
        wait_start("rst", found);
        repeat (3) step();
        rst_in      = 1'b1;
        ctrl_enable = 1'b0;
        step();
        check("rst col idle", xgmii_tx_data, IDLE_COL);
        check("rst count", 72'(frame_count), 72'd0);
        check("rst busy", 72'(busy), 72'd0);
        rst_in = 1'b0;
        bad = 1'b0;
        repeat (12) begin
            step();
            if (xgmii_tx_data !== IDLE_COL || frame_count !== 32'd0) bad = 1'b1;
        end
        check("rst stays idle", 72'(bad), 72'd0);

        // Clear coincident with terminate
        ctrl_enable = 1'b1;
        expect_frame("pre_clr", 64, 12, 32'd0, 1'b1, 14'd64, 8'd12);
        ctrl_num_frames = 32'd2;
        ctrl_enable     = 1'b1;
        wait_start("clr", found);
        ctrl_enable = 1'b0;
        repeat (8) step();
        ctrl_clear = 1'b1;
        step();
        ctrl_clear = 1'b0;
        check("clr term col", xgmii_tx_data, TERM_COL);
        check("clr count", 72'(frame_count), 72'd0);
        check("clr done", 72'(done), 72'd0);
        repeat (5) step();
        check("clr busy low", 72'(busy), 72'd0);
        check("clr count after", 72'(frame_count), 72'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
